// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Load-use stall, branch flush, halt/drain FSM and operand
//            forwarding select for a 5-stage pipeline, with event counters.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  i_id_rs1,
    input  logic [3:0]  i_id_rs2,
    input  logic        i_id_use1,
    input  logic        i_id_use2,
    input  logic [3:0]  i_ex_rd,
    input  logic        i_ex_regwrite,
    input  logic        i_ex_memread,
    input  logic [3:0]  i_mem_rd,
    input  logic        i_mem_regwrite,
    input  logic [3:0]  i_wb_rd,
    input  logic        i_wb_regwrite,
    input  logic        i_branch_taken,
    input  logic        i_halt_req,
    input  logic        i_resume,
    output logic        o_pc_stall,
    output logic        o_ifid_stall,
    output logic        o_ifid_flush,
    output logic        o_idex_bubble,
    output logic [1:0]  o_fwd1,
    output logic [1:0]  o_fwd2,
    output logic        o_halted,
    output logic [15:0] o_stall_cnt,
    output logic [15:0] o_flush_cnt
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    localparam logic [1:0]  c_FWD_RF   = 2'b00;
    localparam logic [1:0]  c_FWD_MEM  = 2'b01;
    localparam logic [1:0]  c_FWD_WB   = 2'b10;
    localparam logic [1:0]  c_DRAIN_LD = 2'd3;
    localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;

    logic [1:0]  r_state;
    logic [1:0]  r_drain_cnt;
    logic [3:0]  r_src1;
    logic [3:0]  r_src2;
    logic        r_src_vld;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic [1:0]  w_next_state;
    logic        w_load_use;
    logic        w_pc_stall;
    logic        w_ifid_stall;
    logic        w_ifid_flush;
    logic        w_idex_bubble;
    logic        w_halted;
    logic        w_stall_inc;

    assign w_load_use = (r_state == RUN) && i_ex_memread && i_ex_regwrite &&
                        ((i_id_use1 && (i_id_rs1 == i_ex_rd)) ||
                         (i_id_use2 && (i_id_rs2 == i_ex_rd)));

    always_comb begin
        w_next_state  = r_state;
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_halted      = 1'b0;
        case (r_state)
            RUN: begin
                if (w_load_use) begin
                    w_pc_stall    = 1'b1;
                    w_ifid_stall  = 1'b1;
                    w_idex_bubble = 1'b1;
                end else if (i_branch_taken) begin
                    w_ifid_flush  = 1'b1;
                end else if (i_halt_req) begin
                    w_pc_stall    = 1'b1;
                    w_next_state  = DRAIN;
                end
            end
            DRAIN: begin
                w_pc_stall    = 1'b1;
                w_ifid_stall  = 1'b1;
                w_idex_bubble = 1'b1;
                // Counter reaches 0 on the same edge that enters HALTED
                if (r_drain_cnt <= 2'd1) begin
                    w_next_state = HALTED;
                end
            end
            HALTED: begin
                w_halted     = 1'b1;
                w_pc_stall   = 1'b1;
                w_ifid_stall = 1'b1;
                if (i_resume) begin
                    w_next_state = RUN;
                end
            end
            default: begin
                w_next_state = RUN;
            end
        endcase
        if (rst) begin
            w_pc_stall    = 1'b0;
            w_ifid_stall  = 1'b0;
            w_ifid_flush  = 1'b0;
            w_idex_bubble = 1'b0;
            w_halted      = 1'b0;
        end
    end

    assign w_stall_inc = w_pc_stall && ((r_state == RUN) || (r_state == DRAIN));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_drain_cnt <= 2'd0;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
            r_src_vld   <= 1'b0;
            r_src1      <= 4'd0;
            r_src2      <= 4'd0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == RUN) && (w_next_state == DRAIN)) begin
                r_drain_cnt <= c_DRAIN_LD;
            end else if ((r_state == DRAIN) && (r_drain_cnt != 2'd0)) begin
                r_drain_cnt <= r_drain_cnt - 2'd1;
            end
            if (w_stall_inc && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_ifid_flush && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
            // A bubble in ID/EX carries no valid sources, so forwarding must not fire
            if (w_idex_bubble) begin
                r_src_vld <= 1'b0;
            end else if (!w_ifid_stall) begin
                r_src_vld <= 1'b1;
                r_src1    <= i_id_rs1;
                r_src2    <= i_id_rs2;
            end
        end
    end

    function automatic logic [1:0] fwd_sel(
        input logic [3:0] src,
        input logic       vld,
        input logic [3:0] mem_rd,
        input logic       mem_we,
        input logic [3:0] wb_rd,
        input logic       wb_we
    );
        logic [1:0] sel;
        sel = c_FWD_RF;
        if (vld && mem_we && (mem_rd == src)) begin
            sel = c_FWD_MEM;
        end else if (vld && wb_we && (wb_rd == src)) begin
            sel = c_FWD_WB;
        end
        return sel;
    endfunction

    assign o_fwd1 = rst ? c_FWD_RF :
                    fwd_sel(r_src1, r_src_vld, i_mem_rd, i_mem_regwrite, i_wb_rd, i_wb_regwrite);
    assign o_fwd2 = rst ? c_FWD_RF :
                    fwd_sel(r_src2, r_src_vld, i_mem_rd, i_mem_regwrite, i_wb_rd, i_wb_regwrite);

    assign o_pc_stall    = w_pc_stall;
    assign o_ifid_stall  = w_ifid_stall;
    assign o_ifid_flush  = w_ifid_flush;
    assign o_idex_bubble = w_idex_bubble;
    assign o_halted      = w_halted;
    assign o_stall_cnt   = r_stall_cnt;
    assign o_flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Directed vector table plus hand-written halt, forwarding, reset
//            and saturation sequences for pipeline_hazard_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_use1, id_use2, ex_regwrite, ex_memread;
    logic        mem_regwrite, wb_regwrite, branch_taken, halt_req, resume;
    logic        pc_stall, ifid_stall, ifid_flush, idex_bubble, halted;
    logic [1:0]  fwd1, fwd2;
    logic [15:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int exp_sc   = 0;
    int exp_fc   = 0;

    typedef struct {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       use1;
        logic       use2;
        logic [3:0] erd;
        logic       erw;
        logic       emr;
        logic       br;
        logic       e_pc;
        logic       e_ifs;
        logic       e_fl;
        logic       e_bub;
    } vec_t;

    vec_t vecs[9];

    pipeline_hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_use1      (id_use1),
        .i_id_use2      (id_use2),
        .i_ex_rd        (ex_rd),
        .i_ex_regwrite  (ex_regwrite),
        .i_ex_memread   (ex_memread),
        .i_mem_rd       (mem_rd),
        .i_mem_regwrite (mem_regwrite),
        .i_wb_rd        (wb_rd),
        .i_wb_regwrite  (wb_regwrite),
        .i_branch_taken (branch_taken),
        .i_halt_req     (halt_req),
        .i_resume       (resume),
        .o_pc_stall     (pc_stall),
        .o_ifid_stall   (ifid_stall),
        .o_ifid_flush   (ifid_flush),
        .o_idex_bubble  (idex_bubble),
        .o_fwd1         (fwd1),
        .o_fwd2         (fwd2),
        .o_halted       (halted),
        .o_stall_cnt    (stall_cnt),
        .o_flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs1 = 4'd0; id_rs2 = 4'd0; id_use1 = 1'b0; id_use2 = 1'b0;
        ex_rd = 4'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = 4'd0; mem_regwrite = 1'b0; wb_rd = 4'd0; wb_regwrite = 1'b0;
        branch_taken = 1'b0; halt_req = 1'b0; resume = 1'b0;
    endtask

    task automatic chk_ctl(input string nm, input logic pc, input logic ifs,
                           input logic fl, input logic bub, input logic hlt);
        chk({nm, "_pc"},  {15'd0, pc_stall},    {15'd0, pc});
        chk({nm, "_ifs"}, {15'd0, ifid_stall},  {15'd0, ifs});
        chk({nm, "_fl"},  {15'd0, ifid_flush},  {15'd0, fl});
        chk({nm, "_bub"}, {15'd0, idex_bubble}, {15'd0, bub});
        chk({nm, "_hlt"}, {15'd0, halted},      {15'd0, hlt});
    endtask

    initial begin
        //          rs1   rs2   u1 u2 erd  erw emr br   pc ifs fl bub
        vecs[0] = '{4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0,  0, 0, 0, 0};
        vecs[1] = '{4'd4, 4'd0, 1, 0, 4'd4, 1, 1, 0,  1, 1, 0, 1};
        vecs[2] = '{4'd0, 4'd9, 0, 1, 4'd9, 1, 1, 0,  1, 1, 0, 1};
        vecs[3] = '{4'd4, 4'd0, 0, 0, 4'd4, 1, 1, 0,  0, 0, 0, 0};
        vecs[4] = '{4'd4, 4'd0, 1, 0, 4'd4, 1, 0, 0,  0, 0, 0, 0};
        vecs[5] = '{4'd4, 4'd0, 1, 0, 4'd4, 0, 1, 0,  0, 0, 0, 0};
        vecs[6] = '{4'd4, 4'd0, 1, 0, 4'd4, 1, 1, 1,  1, 1, 0, 1};
        vecs[7] = '{4'd4, 4'd0, 1, 0, 4'd4, 1, 0, 1,  0, 0, 1, 0};
        vecs[8] = '{4'd4, 4'd5, 1, 1, 4'd5, 1, 1, 0,  1, 1, 0, 1};

        clr();
        rst = 1'b1;
        branch_taken = 1'b1;
        mem_regwrite = 1'b1;
        step();
        step();
        #1;
        chk_ctl("in_rst", 0, 0, 0, 0, 0);
        chk("in_rst_fwd1", {14'd0, fwd1}, 16'd0);
        rst = 1'b0;
        clr();
        step();
        chk("rst_sc", stall_cnt, 16'd0);
        chk("rst_fc", flush_cnt, 16'd0);

        for (int i = 0; i < 9; i++) begin
            clr();
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_use1 = vecs[i].use1; id_use2 = vecs[i].use2;
            ex_rd = vecs[i].erd; ex_regwrite = vecs[i].erw;
            ex_memread = vecs[i].emr; branch_taken = vecs[i].br;
            #2;
            chk_ctl($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_ifs,
                    vecs[i].e_fl, vecs[i].e_bub, 1'b0);
            if (vecs[i].e_pc) exp_sc++;
            if (vecs[i].e_fl) exp_fc++;
            step();
            chk($sformatf("v%0d_sc", i), stall_cnt, exp_sc[15:0]);
            chk($sformatf("v%0d_fc", i), flush_cnt, exp_fc[15:0]);
        end

        // Halt request, three drain cycles, halted, then resume
        clr();
        halt_req = 1'b1;
        #2;
        chk_ctl("halt_req", 1, 0, 0, 0, 0);
        exp_sc++;
        step();
        halt_req = 1'b0;
        for (int d = 0; d < 3; d++) begin
            resume = (d == 1);
            branch_taken = (d == 2);
            #2;
            chk_ctl($sformatf("drain%0d", d), 1, 1, 0, 1, 0);
            exp_sc++;
            step();
        end
        clr();
        branch_taken = 1'b1;
        halt_req = 1'b1;
        #2;
        chk_ctl("halted", 1, 1, 0, 0, 1);
        step();
        chk("halted_sc", stall_cnt, exp_sc[15:0]);
        chk("halted_fc", flush_cnt, exp_fc[15:0]);
        clr();
        resume = 1'b1;
        step();
        resume = 1'b0;
        #1;
        chk_ctl("resumed", 0, 0, 0, 0, 0);

        // Forwarding priority on the registered source copies
        step();
        id_rs1 = 4'd3; id_rs2 = 4'd7;
        step();
        id_rs1 = 4'd0; id_rs2 = 4'd0;
        mem_rd = 4'd7; mem_regwrite = 1'b1; wb_rd = 4'd7; wb_regwrite = 1'b1;
        #1;
        chk("fwd2_both", {14'd0, fwd2}, 16'd1);
        chk("fwd1_none", {14'd0, fwd1}, 16'd0);
        mem_regwrite = 1'b0;
        #1;
        chk("fwd2_wb", {14'd0, fwd2}, 16'd2);
        wb_regwrite = 1'b0;
        #1;
        chk("fwd2_rf", {14'd0, fwd2}, 16'd0);
        wb_rd = 4'd3; wb_regwrite = 1'b1;
        #1;
        chk("fwd1_wb", {14'd0, fwd1}, 16'd2);
        mem_rd = 4'd3; mem_regwrite = 1'b1;
        #1;
        chk("fwd1_mem", {14'd0, fwd1}, 16'd1);
        clr();
        step();
        ex_memread = 1'b1; ex_regwrite = 1'b1; id_use1 = 1'b1;
        exp_sc++;
        step();
        clr();
        mem_regwrite = 1'b1;
        #2;
        chk("fwd1_bubble", {14'd0, fwd1}, 16'd0);
        chk("bub_sc", stall_cnt, exp_sc[15:0]);

        // Reset while draining with counter at 2
        clr();
        step();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        step();
        rst = 1'b1;
        resume = 1'b1;
        #2;
        chk_ctl("rst_drain", 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        resume = 1'b0;
        mem_regwrite = 1'b1;
        #2;
        chk_ctl("post_rst", 0, 0, 0, 0, 0);
        chk("post_rst_sc", stall_cnt, 16'd0);
        chk("post_rst_fc", flush_cnt, 16'd0);
        chk("post_rst_fwd1", {14'd0, fwd1}, 16'd0);

        // Saturation of the stall counter
        clr();
        step();
        ex_memread = 1'b1; ex_regwrite = 1'b1; id_use1 = 1'b1;
        for (int k = 0; k < 65535; k++) begin
            step();
        end
        chk("sat_reach", stall_cnt, 16'hFFFF);
        #1;
        chk("sat_pc", {15'd0, pc_stall}, 16'd1);
        step();
        chk("sat_hold", stall_cnt, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 SHALL have ID-stage inputs: id_rs1 in 4 (Instruction[11:8]); id_rs2 in 4 (Instruction[7:4]); id_use1 in 1 and id_use2 in 1, each meaning the ID instruction reads that operand.
REQ-003 SHALL have EX-stage inputs: ex_rd in 4; ex_regwrite in 1; ex_memread in 1 (the EX instruction is a load).
REQ-004 SHALL have MEM/WB-stage inputs: mem_rd in 4; mem_regwrite in 1; wb_rd in 4; wb_regwrite in 1.
REQ-005 SHALL have event inputs: branch_taken in 1 (BranchingSoFlush from ID); halt_req in 1 (halt opcode in ID); resume in 1, a level that restarts the core from HALTED.
REQ-006 SHALL have outputs: pc_stall out 1; ifid_stall out 1; ifid_flush out 1; idex_bubble out 1; fwd1 out 2; fwd2 out 2 (00 = register file, 01 = EX/MEM ALU result, 10 = MEM/WB result); halted out 1; stall_cnt out 16; flush_cnt out 16.

Function
REQ-007 SHALL implement FSM states RUN, DRAIN, HALTED.
REQ-008 SHALL detect load_use when, in RUN, ex_memread=1 and ex_regwrite=1 and ((id_use1 and id_rs1==ex_rd) or (id_use2 and id_rs2==ex_rd)).
REQ-009 On load_use, SHALL assert pc_stall=1, ifid_stall=1, idex_bubble=1 in the same cycle (Mealy), with ifid_flush=0; the stall SHALL last exactly 1 cycle per hazard.
REQ-010 SHALL give priority in RUN as load_use > branch_taken > halt_req; a branch_taken coinciding with load_use SHALL be ignored that cycle, as its operands are stale.
REQ-011 On branch_taken without load_use, SHALL assert ifid_flush=1 for that cycle only; pc_stall=0 and idex_bubble=0.
REQ-012 On halt_req without load_use or branch_taken, SHALL assert pc_stall=1 and transition to DRAIN with drain counter loaded to 3.
REQ-013 In DRAIN, SHALL hold pc_stall=1, ifid_stall=1 and idex_bubble=1, decrement the drain counter every cycle, and go to HALTED when the counter reaches 0, i.e. after 3 DRAIN cycles.
REQ-014 In HALTED, SHALL assert halted=1, pc_stall=1 and ifid_stall=1, and ignore branch_taken, halt_req and load_use.
REQ-015 In HALTED, resume=1 SHALL return the FSM to RUN on the next edge, with halted=0 from that edge.
REQ-016 resume SHALL be ignored in RUN and DRAIN.
REQ-017 fwd1 (resp. fwd2) SHALL be combinational in all states:
  - 01 if mem_regwrite and mem_rd==ID-EX source register;
  - else 10 if wb_regwrite and wb_rd==source;
  - else 00.
  The EX/MEM match SHALL win when both stages match. Source registers SHALL be registered copies of id_rs1/id_rs2, captured each cycle ifid_stall=0 and idex_bubble=0; a bubble SHALL clear the copies' valid bit, which forces 00.
REQ-018 stall_cnt SHALL increment by 1 on every cycle with pc_stall=1 in RUN or DRAIN, and SHALL saturate at 16'hFFFF.
REQ-019 flush_cnt SHALL increment by 1 per ifid_flush pulse, and SHALL saturate at 16'hFFFF.
REQ-020 ifid_flush and ifid_stall SHALL never be 1 in the same cycle.

Reset
REQ-021 On rst=1 at a clk edge, SHALL set state=RUN, drain counter=0, stall_cnt=0, flush_cnt=0, and source-copy valid bits=0.
REQ-022 While rst=1, SHALL drive all stall/flush/bubble outputs 0, halted=0, fwd1=fwd2=00.
REQ-023 rst SHALL override every other input, including during DRAIN and HALTED; first post-reset cycle state=RUN.

Verification
REQ-024 SHALL cover load-use: ex_memread=1, ex_regwrite=1, ex_rd=4, id_use1=1, id_rs1=4 -> pc_stall=ifid_stall=idex_bubble=1 for 1 cycle; stall_cnt 0->1.
REQ-025 SHALL cover a branch during a stall: load_use and branch_taken both 1 -> ifid_flush=0, flush_cnt unchanged; the next cycle with branch_taken=1 and no hazard -> ifid_flush=1, flush_cnt=1.
REQ-026 SHALL cover halt: halt_req=1 in RUN -> 3 DRAIN cycles with idex_bubble=1, then halted=1; branch_taken in HALTED -> no flush; resume=1 -> RUN, halted=0.
REQ-027 SHALL cover forwarding priority: the ID-EX source copy of id_rs2=7 with mem_rd=7, mem_regwrite=1, wb_rd=7, wb_regwrite=1 -> fwd2=01; with mem_regwrite=0 -> fwd2=10.
REQ-028 SHALL cover reset mid-DRAIN: rst=1 at drain counter=2 -> next cycle state=RUN, counters 0, all outputs 0.
REQ-029 SHALL cover saturation: stall_cnt preloaded via 65535 stall cycles -> an additional stall leaves stall_cnt=16'hFFFF.
